// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory slave with an IDLE/WAIT/RESP handshake.
// Define DMEM_ERR_CHECK_EN to report misaligned or out-of-range accesses on ErrM.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemReadyM,
    output logic        MemStallM,
    output logic        ErrM
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wcnt;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic          lat_byte;

    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_write;
    logic          cur_byte;
    logic          enter_resp;
    logic          err_c;
    logic          do_store;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_data;

    logic [31:0]   mem [DEPTH_WORDS];

    assign MemStallM = MemReqM & ~MemReadyM;

    // With zero wait states the access retires on its accept edge, so live inputs drive it.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = AddrM;
            cur_wdata = WriteDataM;
            cur_write = MemWriteM;
            cur_byte  = ByteM;
        end else begin
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_write = lat_write;
            cur_byte  = lat_byte;
        end
    end

    assign enter_resp = MemReqM &&
                        (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (wcnt == '0)));

    assign idx  = cur_addr[AW+1:2];
    assign lane = cur_addr[1:0];

`ifdef DMEM_ERR_CHECK_EN
    assign err_c = (!cur_byte && (lane != 2'd0)) ||
                   ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    logic unused_addr_hi;
    assign err_c          = 1'b0;
    assign unused_addr_hi = ^cur_addr[31:AW+2];
`endif

    assign do_store = enter_resp & cur_write & ~err_c;
    assign rd_word  = mem[idx];

    always_comb begin
        rd_data = '0;
        if (cur_byte) begin
            rd_data[7:0] = rd_word[{lane, 3'b000} +: 8];
        end else begin
            rd_data = rd_word;
        end
    end

    // The array sits in the reset block only so a store cannot land while reset is low; it is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            MemReadyM <= 1'b0;
            ReadDataM <= '0;
            ErrM      <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
        end else begin
            MemReadyM <= enter_resp;
            ErrM      <= enter_resp & err_c;
            ReadDataM <= (enter_resp && !cur_write && !err_c) ? rd_data : '0;

            if (do_store) begin
                if (cur_byte) begin
                    mem[idx][{lane, 3'b000} +: 8] <= cur_wdata[7:0];
                end else begin
                    mem[idx] <= cur_wdata;
                end
            end

            case (state)
                IDLE: begin
                    if (MemReqM) begin
                        lat_addr  <= AddrM;
                        lat_wdata <= WriteDataM;
                        lat_write <= MemWriteM;
                        lat_byte  <= ByteM;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            wcnt  <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!MemReqM) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else if (wcnt == '0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance checked against a word-array model.
// Expectations follow DMEM_ERR_CHECK_EN when the bench is compiled with it.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        ByteM = 1'b0;
    logic [31:0] AddrM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, stall2, stall0, err2, err0;

    int          total = 0;
    int          bad = 0;
    int          o_lat, o_stall;
    logic [31:0] o_rd;
    logic        o_err;
    logic [31:0] mdl [2][64];

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .MemReqM(req2), .MemWriteM(MemWriteM), .ByteM(ByteM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(rd2), .MemReadyM(rdy2),
        .MemStallM(stall2), .ErrM(err2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(MemWriteM), .ByteM(ByteM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(rd0), .MemReadyM(rdy0),
        .MemStallM(stall0), .ErrM(err0)
    );

    always #5 clk = ~clk;

    // Reference: memory as 64 words, byte lanes by shift/mask, faults from address arithmetic.
    function automatic logic [31:0] model(input bit sel, input logic wr, input logic byt,
                                          input logic [31:0] addr, input logic [31:0] wd,
                                          output logic err);
        int unsigned idx, lane;
        idx  = (addr / 4) % 64;
        lane = addr % 4;
        err  = ERR_EN && ((!byt && lane != 0) || (addr / 4) >= 64);
        if (err) return 32'h0;
        if (wr) begin
            if (byt) mdl[sel][idx][lane*8 +: 8] = wd[7:0];
            else     mdl[sel][idx] = wd;
            return 32'h0;
        end
        if (byt) return (mdl[sel][idx] >> (lane * 8)) & 32'hFF;
        return mdl[sel][idx];
    endfunction

    // One access on the selected instance; inputs are scrambled after acceptance.
    task automatic run(input bit sel, input logic wr, input logic byt,
                       input logic [31:0] addr, input logic [31:0] wd);
        o_lat = -1; o_stall = 0; o_rd = 'x; o_err = 1'bx;
        MemWriteM = wr; ByteM = byt; AddrM = addr; WriteDataM = wd;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        #1;
        if ((sel ? stall0 : stall2) === 1'b1) o_stall++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            MemWriteM = 1'($urandom); ByteM = 1'($urandom);
            AddrM = $urandom; WriteDataM = $urandom;
            #1;
            if ((sel ? rdy0 : rdy2) === 1'b1) begin
                o_lat = i; o_rd = sel ? rd0 : rd2; o_err = sel ? err0 : err2;
                break;
            end
            if ((sel ? stall0 : stall2) === 1'b1) o_stall++;
        end
        req0 = 1'b0; req2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req2 = 1'b1; MemWriteM = 1'b1; AddrM = 32'h10; WriteDataM = $urandom;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rdy2); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rd2); end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err2); end
        total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL reset_stall: got %b want 1", stall2); end
        req2 = 1'b0;
        reset = 1'b1;
        begin
            logic e;
            void'(model(0, 1, 0, 32'h10, 32'hCAFE0010, e));
        end
        run(0, 1, 0, 32'h10, 32'hCAFE0010);
        total++; if (o_lat !== 3) begin bad++; $display("FAIL first_after_reset_latency: got %0d want 3", o_lat); end
    endtask

    task automatic test_init();
        logic e;
        logic [31:0] wd;
        for (int i = 0; i < 64; i++) begin
            for (int s = 0; s < 2; s++) begin
                wd = $urandom;
                void'(model(s[0], 1, 0, 32'(i * 4), wd, e));
                run(s[0], 1, 0, 32'(i * 4), wd);
                total++;
                if (o_lat !== (s == 1 ? 1 : 3)) begin
                    bad++; $display("FAIL init_latency[%0d][%0d]: got %0d want %0d", s, i, o_lat, (s == 1 ? 1 : 3));
                end
            end
        end
    endtask

    task automatic test_word_store_load();
        logic e;
        void'(model(0, 1, 0, 32'h10, 32'hDEADBEEF, e));
        run(0, 1, 0, 32'h10, 32'hDEADBEEF);
        total++; if (o_lat !== 3) begin bad++; $display("FAIL store_latency: got %0d want 3", o_lat); end
        total++; if (o_stall !== 3) begin bad++; $display("FAIL store_stall_cycles: got %0d want 3", o_stall); end
        total++; if (o_rd !== 32'h0) begin bad++; $display("FAIL store_rdata_zero: got %h want 0", o_rd); end
        void'(model(0, 0, 0, 32'h10, 32'h0, e));
        run(0, 0, 0, 32'h10, 32'h0);
        total++; if (o_lat !== 3) begin bad++; $display("FAIL load_latency: got %0d want 3", o_lat); end
        total++; if (o_stall !== 3) begin bad++; $display("FAIL load_stall_cycles: got %0d want 3", o_stall); end
        total++; if (o_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_word: got %h want deadbeef", o_rd); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL load_word_err: got %b want 0", o_err); end
    endtask

    task automatic test_byte_lanes();
        logic e;
        logic [31:0] wd;
        void'(model(0, 1, 0, 32'h20, 32'h11223344, e));
        run(0, 1, 0, 32'h20, 32'h11223344);
        wd = {24'($urandom), 8'hAA};
        void'(model(0, 1, 1, 32'h21, wd, e));
        run(0, 1, 1, 32'h21, wd);
        run(0, 0, 0, 32'h20, 32'h0);
        total++; if (o_rd !== 32'h1122AA44) begin bad++; $display("FAIL byte_store_merge: got %h want 1122aa44", o_rd); end
        run(0, 0, 1, 32'h22, 32'h0);
        total++; if (o_rd !== 32'h00000022) begin bad++; $display("FAIL byte_load_lane2: got %h want 00000022", o_rd); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL byte_load_err: got %b want 0", o_err); end
    endtask

    task automatic test_abort();
        logic e;
        logic [31:0] prior;
        bit seen;
        prior = $urandom;
        void'(model(0, 1, 0, 32'h30, prior, e));
        run(0, 1, 0, 32'h30, prior);
        MemWriteM = 1'b1; ByteM = 1'b0; AddrM = 32'h30; WriteDataM = ~prior; req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rdy2 !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_ready: got ready=1 want 0"); end
        run(0, 0, 0, 32'h30, 32'h0);
        total++; if (o_rd !== prior) begin bad++; $display("FAIL abort_no_store: got %h want %h", o_rd, prior); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old40, old44;
        old40 = mdl[0][16];
        old44 = mdl[0][17];
        MemWriteM = 1'b1; ByteM = 1'b0; AddrM = 32'h40; WriteDataM = ~old40; req2 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", rdy2); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL midreset_rdata: got %h want 0", rd2); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL midreset_ready_held: got %b want 0", rdy2); end
        req2 = 1'b0;
        reset = 1'b1;
        run(0, 0, 0, 32'h40, 32'h0);
        total++; if (o_lat !== 3) begin bad++; $display("FAIL post_reset_latency: got %0d want 3", o_lat); end
        total++; if (o_rd !== old40) begin bad++; $display("FAIL midreset_no_store: got %h want %h", o_rd, old40); end

        MemWriteM = 1'b0; ByteM = 1'b0; AddrM = 32'h44; req2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rd2 !== old44) begin bad++; $display("FAIL resp_load_before_reset: got %h want %h", rd2, old44); end
        reset = 1'b0;
        #1;
        total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL reset_in_resp_ready: got %b want 0", rdy2); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL reset_in_resp_rdata: got %h want 0", rd2); end
        req2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        logic e;
        logic [31:0] exp;
        exp = model(0, 0, 0, 32'h13, 32'h0, e);
        run(0, 0, 0, 32'h13, 32'h0);
        total++; if (o_err !== e) begin bad++; $display("FAIL fault_misaligned_err: got %b want %b", o_err, e); end
        total++; if (o_rd !== exp) begin bad++; $display("FAIL fault_misaligned_rdata: got %h want %h", o_rd, exp); end
        exp = model(0, 0, 0, 32'h100, 32'h0, e);
        run(0, 0, 0, 32'h100, 32'h0);
        total++; if (o_err !== ERR_EN) begin bad++; $display("FAIL fault_range_err: got %b want %b", o_err, ERR_EN); end
        total++; if (o_rd !== (ERR_EN ? 32'h0 : mdl[0][0])) begin
            bad++; $display("FAIL fault_range_rdata: got %h want %h", o_rd, exp);
        end
        void'(model(0, 1, 0, 32'h104, 32'h5A5A0104, e));
        run(0, 1, 0, 32'h104, 32'h5A5A0104);
        total++; if (o_lat !== 3) begin bad++; $display("FAIL fault_store_latency: got %0d want 3", o_lat); end
        exp = model(0, 0, 0, 32'h4, 32'h0, e);
        run(0, 0, 0, 32'h4, 32'h0);
        total++; if (o_rd !== exp) begin bad++; $display("FAIL fault_store_effect: got %h want %h", o_rd, exp); end
    endtask

    task automatic test_back_to_back_zero_wait();
        logic [31:0] ad [8];
        logic        by [8];
        logic [31:0] ex [8];
        logic        e;
        int          k;
        for (int i = 0; i < 8; i++) begin
            by[i] = 1'($urandom);
            ad[i] = by[i] ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63) * 4);
            ex[i] = model(1, 0, by[i], ad[i], 32'h0, e);
        end
        k = 0;
        MemWriteM = 1'b0; ByteM = by[0]; AddrM = ad[0]; req0 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            total++;
            if (rdy0 !== 1'(c % 2)) begin
                bad++; $display("FAIL b2b_ready_cycle%0d: got %b want %b", c, rdy0, 1'(c % 2));
            end
            if (c % 2 == 1) begin
                total++;
                if (rd0 !== ex[k]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rd0, ex[k]); end
                k++;
                if (k < 8) begin ByteM = by[k]; AddrM = ad[k]; end
                else req0 = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        e, wr, byt, sel;
        logic [31:0] addr, wd, exp;
        for (int n = 0; n < 80; n++) begin
            sel  = 1'($urandom);
            wr   = 1'($urandom);
            byt  = 1'($urandom);
            addr = 32'($urandom_range(0, 'h1FF));
            if (!byt && ($urandom % 4) != 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            exp  = model(sel, wr, byt, addr, wd, e);
            run(sel, wr, byt, addr, wd);
            total++;
            if (o_lat !== (sel ? 1 : 3)) begin
                bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, o_lat, (sel ? 1 : 3));
            end
            total++;
            if (o_rd !== exp) begin
                bad++; $display("FAIL rand_rdata[%0d] sel=%0d wr=%0d byte=%0d addr=%h: got %h want %h",
                                n, sel, wr, byt, addr, o_rd, exp);
            end
            total++;
            if (o_err !== e) begin bad++; $display("FAIL rand_err[%0d] addr=%h: got %b want %b", n, addr, o_err, e); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_store_load();
        test_byte_lanes();
        test_abort();
        test_reset_mid();
        test_faults();
        test_back_to_back_zero_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001: Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit words in the internal array; it SHALL be a power of two.
- REQ-002: Parameter WAIT_CYCLES, default 2, SHALL set the number of wait states inserted per access, with range 0..15.
- REQ-003: The block SHALL have one clock and an asynchronous, active-low reset, named as follows:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low reset.
- REQ-004: The remaining ports SHALL be:
  - MemReqM  in  1  access request, held by the datapath until MemReadyM.
  - MemWriteM  in  1  1 = store, 0 = load.
  - ByteM  in  1  1 = byte access (LDRB/STRB), 0 = word access.
  - AddrM  in  32  byte address (ALUOutM).
  - WriteDataM  in  32  store data; a byte store uses [7:0].
  - ReadDataM  out  32  load data, valid only while MemReadyM=1.
  - MemReadyM  out  1  one-cycle completion pulse.
  - MemStallM  out  1  stall request to the hazard unit.
  - ErrM  out  1  access fault, valid only while MemReadyM=1.

Function
- REQ-005: The FSM SHALL have three states: IDLE, WAIT and RESP.
- REQ-006: In IDLE, MemReqM=1 SHALL latch AddrM, WriteDataM, MemWriteM and ByteM. The next state SHALL be WAIT if WAIT_CYCLES>0, otherwise RESP.
- REQ-007: WAIT SHALL count latched wait cycles from WAIT_CYCLES-1 down to 0, then go to RESP. MemReadyM SHALL therefore rise WAIT_CYCLES+1 cycles after the request is accepted.
- REQ-008: RESP SHALL last exactly one cycle with MemReadyM=1, then return to IDLE unconditionally.
- REQ-009: A store SHALL update the array at the clock edge that enters RESP.
  - A word store SHALL write all 32 bits.
  - A byte store SHALL write only byte lane AddrM[1:0], leaving the other lanes unchanged.
- REQ-010: A load in RESP SHALL drive the following on ReadDataM:
  - word load: the addressed word;
  - byte load: the lane selected by AddrM[1:0], zero-extended to 32 bits.
- REQ-011: Outside RESP, or on a store, ReadDataM SHALL be 0.
- REQ-012: MemStallM SHALL equal MemReqM & ~MemReadyM, combinationally.
- REQ-013: If MemReqM drops while in WAIT, the FSM SHALL abort to IDLE on the next edge. No store SHALL be performed and no MemReadyM SHALL be issued.
- REQ-014: Inputs that change after acceptance SHALL be ignored; the latched values govern the access.
- REQ-015: Back-to-back accesses: a request present in the IDLE cycle after RESP SHALL be accepted in that cycle. The minimum spacing SHALL be WAIT_CYCLES+2 cycles.
- REQ-016: The word index SHALL be AddrM[log2(DEPTH_WORDS)+1:2].

Reset
- REQ-017: While reset=0, the following SHALL be forced, asynchronously: state=IDLE, wait counter=0, MemReadyM=0, ReadDataM=0, ErrM=0.
- REQ-018: Reset asserted mid-access SHALL discard the access with no store. Array contents SHALL NOT be cleared by reset.
- REQ-019: The first request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
- REQ-020: The macro DMEM_ERR_CHECK_EN SHALL select fault checking, as follows.
- REQ-021: With DMEM_ERR_CHECK_EN defined, an access SHALL fault if either condition holds:
  - a word access has AddrM[1:0]!=0;
  - AddrM[31:2]>=DEPTH_WORDS.
- REQ-022: A faulting access SHALL still complete with normal latency and MemReadyM=1, with ErrM=1, ReadDataM=0 and no store.
- REQ-023: With DMEM_ERR_CHECK_EN undefined, ErrM SHALL be tied to 0. Word accesses SHALL ignore AddrM[1:0], and addresses SHALL wrap modulo DEPTH_WORDS.

Verification
- REQ-024: The bench SHALL cover these directed scenarios (DEPTH_WORDS=64, WAIT_CYCLES=2 unless noted):
  - Word store then load: store 0xDEADBEEF to 0x10, then load 0x10. MemReadyM SHALL pulse 3 cycles after each acceptance, the load SHALL return 0xDEADBEEF, and MemStallM SHALL be 1 for 3 cycles per access.
  - Byte lanes: store word 0x11223344 to 0x20, STRB 0xAA to 0x21, then load word 0x20 and LDRB 0x22. The responses SHALL be 0x1122AA44 and 0x00000022.
  - Abort: a store to 0x30 with MemReqM dropped in the first WAIT cycle SHALL produce no MemReadyM, and a later load of 0x30 SHALL return the prior value.
  - Reset mid-access: reset=0 in WAIT SHALL immediately give MemReadyM=0 and state IDLE, with no store. A load issued after reset release SHALL complete normally.
  - Faults with DMEM_ERR_CHECK_EN defined: a word load at 0x13 and a word load at 0x100 SHALL each give ErrM=1 and ReadDataM=0. Without the macro, 0x100 SHALL alias to 0x0 and 0x13 SHALL read word 0x10.
  - Zero wait states (WAIT_CYCLES=0): back-to-back loads SHALL complete with MemReadyM on every second cycle.
